// File: rtl/noc_pkg.sv
// noc_pkg: flit encodings, FSM states and head-flit field offsets shared by the injection stage.
package noc_pkg;
    typedef enum logic [1:0] {
        FLIT_BODY = 2'b00,
        FLIT_HEAD = 2'b01,
        FLIT_TAIL = 2'b10
    } flit_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEAD,
        ST_PAYLOAD
    } state_e;

    localparam int HEAD_DEST_POS = 0;

    function automatic int head_src_pos(input int addr_w);
        return addr_w;
    endfunction

    function automatic int head_len_pos(input int addr_w);
        return 2 * addr_w;
    endfunction
endpackage

// File: rtl/noc_credit_ctr.sv
// noc_credit_ctr: router buffer credit counter, saturating at CREDITS.
module noc_credit_ctr #(
    parameter  int CREDITS = 4,
    localparam int CW      = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dec,
    input  logic          inc,
    output logic [CW-1:0] count
);
    logic [CW-1:0] count_q, count_d;

    // A return at full count is a protocol violation and is dropped.
    always_comb begin
        count_d = (inc && !dec && count_q != CW'(CREDITS)) ? count_q + CW'(1) :
                  (dec && !inc)                            ? count_q - CW'(1) : count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= CW'(CREDITS);
        else     count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/noc_inject.sv
// noc_inject: serialises client messages into HEAD/BODY/TAIL flits under credit flow control.
module noc_inject
    import noc_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int ADDR_W  = 4,
    parameter  int MAX_LEN = 4,
    parameter  int CREDITS = 4,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         src_id,
    input  logic                      msg_valid,
    output logic                      msg_ready,
    input  logic [ADDR_W-1:0]         msg_dest,
    input  logic [LEN_W-1:0]          msg_len,
    input  logic [MAX_LEN*DATA_W-1:0] msg_data,
    output logic                      flit_valid,
    output logic [1:0]                flit_type,
    output logic [DATA_W-1:0]         flit_data,
    input  logic                      credit_in,
    output logic                      busy
);
    localparam int IDX_W   = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
    localparam int CW      = $clog2(CREDITS + 1);
    localparam int SRC_POS = head_src_pos(ADDR_W);
    localparam int LEN_POS = head_len_pos(ADDR_W);

    state_e                           state_q, state_d;
    logic [ADDR_W-1:0]                dest_q, dest_d;
    logic [LEN_W-1:0]                 len_q, len_d, len_in;
    logic [MAX_LEN-1:0][DATA_W-1:0]   data_q, data_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [CW-1:0]                    credits;
    logic [DATA_W-1:0]                head;
    logic                             accept, send, last;

    noc_credit_ctr #(.CREDITS(CREDITS)) u_cred (
        .clk   (clk),
        .rst   (rst),
        .dec   (send),
        .inc   (credit_in),
        .count (credits)
    );

    assign msg_ready = state_q == ST_IDLE;
    assign busy      = state_q != ST_IDLE;
    assign accept    = msg_valid && msg_ready;
    assign send      = busy && credits != '0;
    assign last      = LEN_W'(idx_q) == len_q - LEN_W'(1);
    assign len_in    = msg_len == '0 ? LEN_W'(1) :
                       msg_len > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : msg_len;

    always_comb begin
        head = '0;
        head[HEAD_DEST_POS +: ADDR_W] = dest_q;
        head[SRC_POS +: ADDR_W]       = src_id;
        head[LEN_POS +: LEN_W]        = len_q;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dest_d  = accept ? msg_dest : dest_q;
        len_d   = accept ? len_in : len_q;
        data_d  = accept ? msg_data : data_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                state_d = ST_HEAD;
                idx_d   = '0;
            end
            ST_HEAD: if (send) state_d = ST_PAYLOAD;
            ST_PAYLOAD: if (send) begin
                state_d = last ? ST_IDLE : ST_PAYLOAD;
                idx_d   = idx_q + IDX_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            dest_q  <= '0;
            len_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dest_q  <= dest_d;
            len_q   <= len_d;
            data_q  <= data_d;
        end
    end

    assign flit_valid = send;
    assign flit_type  = !send ? 2'b00 : state_q == ST_HEAD ? FLIT_HEAD : last ? FLIT_TAIL : FLIT_BODY;
    assign flit_data  = !send ? '0 : state_q == ST_HEAD ? head : data_q[idx_q];
endmodule

// File: doc/noc_inject.md
# noc_inject

Network injection stage sitting directly upstream of the `noc` router fabric at a source port. It accepts whole messages from a local client through a valid/ready handshake. It serialises each message into a HEAD flit followed by one flit per payload word, the last of which is a TAIL. Flits are issued under credit-based flow control against the router input buffer.

## Interface

- `DATA_W`, 32, flit/payload word width
- `ADDR_W`, 4, node address width (`DATA_W >= 2*ADDR_W+LEN_W`)
- `MAX_LEN`, 4, maximum payload words per message
- `CREDITS`, 4, router input-buffer depth in flits
- `LEN_W`, `$clog2(MAX_LEN+1)`, derived length width
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `src_id`  in  ADDR_W  this node's address, static after reset
- `msg_valid`  in  1  client offers a message
- `msg_ready`  out  1  block can accept a message
- `msg_dest`  in  ADDR_W  destination node
- `msg_len`  in  LEN_W  payload word count
- `msg_data`  in  MAX_LEN*DATA_W  payload; word i at `[i*DATA_W +: DATA_W]`
- `flit_valid`  out  1  flit presented to router this cycle
- `flit_type`  out  2  HEAD=2'b01, BODY=2'b00, TAIL=2'b10
- `flit_data`  out  DATA_W  flit payload
- `credit_in`  in  1  router freed one buffer slot (one-cycle pulse)
- `busy`  out  1  packet in flight (state != IDLE)

## Operation

- FSM states: IDLE, HEAD, PAYLOAD.
- IDLE: `msg_ready`=1. On `msg_valid && msg_ready`, capture dest, len, data into registers, clear word index, go to HEAD.
- Length coercion at capture: `msg_len==0` is treated as 1; `msg_len>MAX_LEN` is treated as MAX_LEN.
- HEAD: `flit_valid` = (credit count != 0).
  - HEAD flit data: `[ADDR_W-1:0]`=dest, `[2*ADDR_W-1:ADDR_W]`=src_id, next LEN_W bits=coerced len, remaining bits 0.
  - When sent, go to PAYLOAD.
- PAYLOAD: `flit_valid` = (credit count != 0); `flit_data` = word[index].
  - `flit_type` is TAIL when index==len-1, otherwise BODY.
  - Each sent flit increments index. Sending the TAIL returns the FSM to IDLE.
- A flit is "sent" on any cycle where `flit_valid`=1. The router has no ready signal; credits guarantee acceptance.
- Credit counter, width `$clog2(CREDITS+1)`, reset to CREDITS:
  - −1 on a sent flit; +1 on `credit_in`; both in the same cycle leaves it unchanged.
  - `credit_in` while the count is already CREDITS is a protocol violation. The count saturates at CREDITS and the pulse is ignored.
- When `flit_valid`=0, `flit_type` and `flit_data` are don't-care; the implementation drives 0.
- Reset mid-packet aborts the packet: FSM goes to IDLE, credits return to CREDITS, and no TAIL is emitted. The router is reset by the same `rst`.

## Timing

- Reset values: `msg_ready`=1, `flit_valid`=0, `flit_type`=0, `flit_data`=0, `busy`=0; credits=CREDITS.
- Accept at edge k → HEAD flit valid in cycle k+1 if credits>0.
- With credits available, a packet streams one flit per cycle: len+1 consecutive cycles.
- Flit outputs are derived only from registered state, with no combinational path from `credit_in`, `msg_valid` or `msg_data` to `flit_*`. A credit returned at edge k can enable a flit in cycle k+1.
- `msg_ready` drops the cycle after acceptance and rises the cycle after the TAIL is sent. The minimum gap between accepts is len+2 cycles.
- Zero credits stall the current flit indefinitely; registers hold and `flit_valid` stays 0.

## Structure

- Shared package `noc_pkg`:
  - `flit_type_e` (HEAD/BODY/TAIL encodings)
  - head-field offset constants
  - FSM `state_e`
- Sub-module `noc_credit_ctr` (parameter CREDITS): inputs `dec`, `inc`; output `count`. Handles saturation and the simultaneous inc/dec case.

## Test plan

- Reset: assert `rst` 2 cycles → `msg_ready`=1, `flit_valid`=0, `busy`=0, credit count 4.
- Send dest=3, src_id=1, len=1, word0=0xDEADBEEF:
  - cycle+1: HEAD, data=0x00000113
  - cycle+2: TAIL, 0xDEADBEEF
  - `msg_ready` back at cycle+3.
- Send len=4 with no `credit_in`:
  - HEAD plus 3 BODY flits, then stall with `flit_valid`=0.
  - One `credit_in` pulse → TAIL (word3) on the next cycle.
- Credits at 1, `credit_in` pulsed in the same cycle a flit is sent → count stays 1, streaming continues without a bubble.
- Assert `rst` during the 2nd BODY of a len=4 packet → next cycle `flit_valid`=0, `msg_ready`=1, credits=4; the next message starts with a clean HEAD.
- Edge cases:
  - `msg_len`=0 → HEAD with len field 1, then TAIL carrying word0.
  - `msg_len`=7 → clamped to 4 (HEAD len field 4, 4 payload flits).
  - `credit_in` at full count → count stays 4.
